// File: rtl/ccff_pkg.sv
// Shared types and constants for the connection-block config chain loader.
// Holds the loader FSM encoding and the serial CRC-16-CCITT step used by the optional verify pass.
package ccff_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        VERIFY,
        DONE
    } ccff_state_t;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // One serial CRC-16-CCITT step, MSB-first (feedback = crc[15] ^ incoming bit).
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        crc16_step = {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/ccff_crc16.sv
// Serial-in CRC-16-CCITT accumulator, one bit per enabled prog_clk edge.
// Latency: crc reflects a bit on the edge after it is presented; clr wins over en.
// Backpressure: none, accumulates whenever en is high.
module ccff_crc16
    import ccff_pkg::*;
(
    input  logic        prog_clk,
    input  logic        prog_reset_n,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            crc <= CRC16_INIT;
        end else if (clr) begin
            crc <= CRC16_INIT;
        end else if (en) begin
            crc <= crc16_step(crc, din);
        end
    end

endmodule

// File: rtl/cbx_ccff_loader.sv
// Programs one cbx ccff chain from a word stream: 1 accept cycle + WORD_W shift cycles per word, then a done pulse.
// Backpressure: s_ready only in LOAD, so the host stalls during shifting; abort returns to IDLE from any state.
// Optional CBX_CCFF_VERIFY_EN adds a recirculating CRC verify pass (CHAIN_LEN extra cycles) and sticky cfg_err.
module cbx_ccff_loader
    import ccff_pkg::*;
#(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic [CNT_W-1:0]  bit_cnt
);

    localparam int WB_W = $clog2(WORD_W + 1);

    generate
        if (CHAIN_LEN % WORD_W != 0) begin : g_len_chk
            $error("cbx_ccff_loader: CHAIN_LEN must be a multiple of WORD_W");
        end
    endgenerate

`ifdef CBX_CCFF_VERIFY_EN
    localparam ccff_state_t FULL_NXT = VERIFY;
`else
    localparam ccff_state_t FULL_NXT = DONE;
`endif

    ccff_state_t       state;
    ccff_state_t       state_nxt;
    logic [WORD_W-1:0] shreg;
    logic [WB_W-1:0]   word_bit;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_inc;
    logic              word_last;
    logic              chain_full;
    logic              verify_last;
    logic              start_ok;
    logic              shift_en_q;
    logic              s_ready_q;
    logic              busy_q;
    logic              done_q;

    assign start_ok   = (state == IDLE) && start && !abort;
    assign cnt_inc    = cnt_q + 1'b1;
    assign word_last  = (word_bit == WB_W'(WORD_W - 1));
    assign chain_full = (cnt_inc == CNT_W'(CHAIN_LEN));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = LOAD;
            LOAD:    if (s_valid) state_nxt = SHIFT;
            SHIFT:   if (word_last) state_nxt = chain_full ? FULL_NXT : LOAD;
            VERIFY:  if (verify_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Strobes are flopped from state_nxt so shift_en and the head bit leave flops on the same edge.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            shift_en_q <= 1'b0;
            s_ready_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            shift_en_q <= (state_nxt == SHIFT) || (state_nxt == VERIFY);
            s_ready_q  <= (state_nxt == LOAD);
            busy_q     <= (state_nxt != IDLE);
            done_q     <= (state_nxt == DONE);
        end
    end

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            shreg    <= '0;
            word_bit <= '0;
            cnt_q    <= '0;
        end else if (abort) begin
            // bit_cnt is left as-is so software can see how far the load got.
            shreg    <= '0;
            word_bit <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) cnt_q <= '0;
                end
                LOAD: begin
                    if (s_valid) begin
                        shreg    <= s_data;
                        word_bit <= '0;
                    end
                end
                SHIFT: begin
                    shreg    <= {shreg[WORD_W-2:0], 1'b0};
                    word_bit <= word_bit + 1'b1;
                    if (cnt_q != CNT_W'(CHAIN_LEN)) cnt_q <= cnt_inc;
                end
                default: ;
            endcase
        end
    end

    assign s_ready       = s_ready_q;
    assign ccff_shift_en = shift_en_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign bit_cnt       = cnt_q;

`ifdef CBX_CCFF_VERIFY_EN
    logic [CNT_W-1:0] vcnt;
    logic [15:0]      crc_head;
    logic [15:0]      crc_tail;
    logic             cfg_err_q;

    assign verify_last = (vcnt == CNT_W'(CHAIN_LEN - 1));

    // Recirculating tail into head rotates the chain a full turn, leaving its contents intact.
    assign ccff_head = (state == VERIFY) ? ccff_tail : shreg[WORD_W-1];

    ccff_crc16 u_crc_head (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .clr          (start_ok),
        .en           (state == SHIFT),
        .din          (ccff_head),
        .crc          (crc_head)
    );

    ccff_crc16 u_crc_tail (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .clr          (start_ok),
        .en           (state == VERIFY),
        .din          (ccff_tail),
        .crc          (crc_tail)
    );

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            vcnt      <= '0;
            cfg_err_q <= 1'b0;
        end else if (abort) begin
            vcnt <= '0;
        end else if (start_ok) begin
            vcnt      <= '0;
            cfg_err_q <= 1'b0;
        end else if (state == VERIFY) begin
            vcnt <= vcnt + 1'b1;
            // Fold in the final tail bit so the flag is already valid during the done pulse.
            if (verify_last) cfg_err_q <= (crc_head != crc16_step(crc_tail, ccff_tail));
        end
    end

    assign cfg_err = cfg_err_q;
`else
    logic unused_tail;

    assign unused_tail = ccff_tail;
    assign verify_last = 1'b0;
    assign ccff_head   = shreg[WORD_W-1];
    assign cfg_err     = 1'b0;
`endif

endmodule

// File: tb/tb_cbx_ccff_loader.sv
// Directed/random bench for cbx_ccff_loader against a behavioural chain model and word-level expectations.
// Compile with CBX_CCFF_VERIFY_EN defined to also exercise the CRC verify pass and stuck-at detection.
module tb_cbx_ccff_loader;

    localparam int CHAIN_LEN = 64;
    localparam int WORD_W    = 8;
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
    localparam int NW        = CHAIN_LEN / WORD_W;
`ifdef CBX_CCFF_VERIFY_EN
    localparam int VFY_CYC = CHAIN_LEN;
`else
    localparam int VFY_CYC = 0;
`endif
    // Cycles from the accept cycle of a word to the done cycle (verify build: 136, i.e. 137 counting both ends).
    localparam int LAT_FIRST = NW * (WORD_W + 1) + VFY_CYC;
    localparam int LAT_LAST  = (WORD_W + 1) + VFY_CYC;

    logic              prog_clk;
    logic              prog_reset_n;
    logic              start;
    logic              abort;
    logic [WORD_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic              ccff_head;
    logic              ccff_shift_en;
    logic              ccff_tail;
    logic              busy;
    logic              done;
    logic              cfg_err;
    logic [CNT_W-1:0]  bit_cnt;

    cbx_ccff_loader #(
        .CHAIN_LEN (CHAIN_LEN),
        .WORD_W    (WORD_W)
    ) dut (
        .prog_clk      (prog_clk),
        .prog_reset_n  (prog_reset_n),
        .start         (start),
        .abort         (abort),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_tail     (ccff_tail),
        .busy          (busy),
        .done          (done),
        .cfg_err       (cfg_err),
        .bit_cnt       (bit_cnt)
    );

    initial begin
        prog_clk = 1'b0;
        forever #5 prog_clk = ~prog_clk;
    end

    // Behavioural chain: a CHAIN_LEN-bit shift register, head enters at bit 0, tail is the top bit.
    logic [CHAIN_LEN-1:0] chain = '0;
    logic [CHAIN_LEN-1:0] chain_nxt;
    logic                 stuck = 1'b0;
    int                   cyc = 0;
    int                   shift_cnt = 0;
    int                   done_cnt = 0;

    assign ccff_tail = chain[CHAIN_LEN-1];

    always @(posedge prog_clk) begin
        cyc <= cyc + 1;
        if (ccff_shift_en) begin
            chain_nxt = {chain[CHAIN_LEN-2:0], ccff_head};
            if (stuck) chain_nxt[17] = 1'b1;
            chain     <= chain_nxt;
            shift_cnt <= shift_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    int                checks = 0;
    int                errors = 0;
    logic [WORD_W-1:0] words [NW];
    int                first_acc;
    int                last_acc;
    int                sc0;
    int                dn0;
    bit                stopped;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CHAIN_LEN-1:0] expected_chain();
        logic [CHAIN_LEN-1:0] v = '0;
        for (int i = 0; i < NW; i++) v = (v << WORD_W) | CHAIN_LEN'(words[i]);
        return v;
    endfunction

    task automatic start_pulse();
        sc0 = shift_cnt;
        dn0 = done_cnt;
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        check("start_bit_cnt_clear", 64'(bit_cnt), 64'd0);
        check("start_cfg_err_clear", 64'(cfg_err), 64'd0);
        check("start_s_ready", 64'(s_ready), 64'd1);
    endtask

    task automatic do_load(input int gap_max, input bit start_mid, input int stop_at, output bit stop_hit);
        stop_hit = 1'b0;
        for (int i = 0; i < NW; i++) begin
            int gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            int t = 0;
            s_valid = 1'b0;
            repeat (gap) @(negedge prog_clk);
            s_data  = words[i];
            s_valid = 1'b1;
            while (!s_ready && t < 200) begin
                if (stop_at >= 0 && int'(bit_cnt) == stop_at) begin
                    s_valid  = 1'b0;
                    stop_hit = 1'b1;
                    return;
                end
                @(negedge prog_clk);
                t++;
            end
            check("accept_wait", 64'(s_ready), 64'd1);
            if (!s_ready) begin
                s_valid = 1'b0;
                return;
            end
            if (i == 0) first_acc = cyc;
            last_acc = cyc;
            @(negedge prog_clk);
            s_valid = 1'b0;
            check("shift_after_accept", 64'(ccff_shift_en), 64'd1);
            if (start_mid && i == 0) begin
                start = 1'b1;
                @(negedge prog_clk);
                start = 1'b0;
            end
        end
    endtask

    task automatic finish_load(input bit chk_first, input bit exp_err, input bit chk_chain);
        int dc = -1;
        for (int t = 0; t < 2000; t++) begin
            if (done) begin
                dc = cyc;
                break;
            end
            @(negedge prog_clk);
        end
        check("done_seen", 64'(dc >= 0), 64'd1);
        if (chk_first) check("latency_first", 64'(dc - first_acc), 64'(LAT_FIRST));
        check("latency_last", 64'(dc - last_acc), 64'(LAT_LAST));
        check("done_busy", 64'(busy), 64'd1);
        check("done_bit_cnt", 64'(bit_cnt), 64'(CHAIN_LEN));
        check("done_cfg_err", 64'(cfg_err), 64'(exp_err));
        check("shift_count", 64'(shift_cnt - sc0), 64'(CHAIN_LEN + VFY_CYC));
        if (chk_chain) check("chain_contents", 64'(chain), 64'(expected_chain()));
        @(negedge prog_clk);
        check("done_one_cycle", 64'(done), 64'd0);
        check("busy_after_done", 64'(busy), 64'd0);
        check("done_count", 64'(done_cnt - dn0), 64'd1);
    endtask

    initial begin
        start        = 1'b0;
        abort        = 1'b0;
        s_data       = '0;
        s_valid      = 1'b0;
        prog_reset_n = 1'b1;
        #1 prog_reset_n = 1'b0;
        repeat (3) @(negedge prog_clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_shift_en", 64'(ccff_shift_en), 64'd0);
        check("rst_head", 64'(ccff_head), 64'd0);
        check("rst_cfg_err", 64'(cfg_err), 64'd0);
        check("rst_bit_cnt", 64'(bit_cnt), 64'd0);
        prog_reset_n = 1'b1;
        repeat (2) @(negedge prog_clk);

        // Basic back-to-back load of 0x01..0x08.
        for (int i = 0; i < NW; i++) words[i] = WORD_W'(i + 1);
        start_pulse();
        do_load(0, 1'b0, -1, stopped);
        finish_load(1'b1, 1'b0, 1'b1);

        // Random words with host gaps; the second load also pulses start mid-shift.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NW; i++) words[i] = WORD_W'($urandom);
            start_pulse();
            do_load(12, r == 1, -1, stopped);
            finish_load(1'b0, 1'b0, 1'b1);
        end

        // Abort at bit 20: drops to idle with bit_cnt frozen and no done.
        for (int i = 0; i < NW; i++) words[i] = WORD_W'($urandom);
        start_pulse();
        do_load(0, 1'b0, 20, stopped);
        check("abort_reached", 64'(stopped), 64'd1);
        abort = 1'b1;
        @(negedge prog_clk);
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_shift_en", 64'(ccff_shift_en), 64'd0);
        check("abort_s_ready", 64'(s_ready), 64'd0);
        check("abort_bit_cnt", 64'(bit_cnt), 64'd20);
        repeat (10) @(negedge prog_clk);
        check("abort_no_done", 64'(done_cnt - dn0), 64'd0);
        abort = 1'b1;
        start = 1'b1;
        @(negedge prog_clk);
        abort = 1'b0;
        start = 1'b0;
        check("abort_beats_start", 64'(busy), 64'd0);
        check("abort_start_bit_cnt", 64'(bit_cnt), 64'd20);
        start_pulse();
        do_load(0, 1'b0, -1, stopped);
        finish_load(1'b1, 1'b0, 1'b1);

        // Async reset at bit 33, then a clean reload.
        for (int i = 0; i < NW; i++) words[i] = WORD_W'($urandom);
        start_pulse();
        do_load(0, 1'b0, 33, stopped);
        check("reset_point_reached", 64'(stopped), 64'd1);
        prog_reset_n = 1'b0;
        #1;
        check("mid_rst_shift_en", 64'(ccff_shift_en), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_bit_cnt", 64'(bit_cnt), 64'd0);
        check("mid_rst_head", 64'(ccff_head), 64'd0);
        check("mid_rst_s_ready", 64'(s_ready), 64'd0);
        @(negedge prog_clk);
        prog_reset_n = 1'b1;
        @(negedge prog_clk);
        check("post_rst_idle", 64'(busy), 64'd0);
        for (int i = 0; i < NW; i++) words[i] = WORD_W'($urandom);
        start_pulse();
        do_load(0, 1'b0, -1, stopped);
        finish_load(1'b1, 1'b0, 1'b1);

`ifdef CBX_CCFF_VERIFY_EN
        // Chain bit 17 stuck-at-1 with an all-zero load must be flagged, and the flag clears on start.
        stuck = 1'b1;
        for (int i = 0; i < NW; i++) words[i] = '0;
        start_pulse();
        do_load(0, 1'b0, -1, stopped);
        finish_load(1'b1, 1'b1, 1'b0);
        check("err_sticky_idle", 64'(cfg_err), 64'd1);
        stuck = 1'b0;
        for (int i = 0; i < NW; i++) words[i] = WORD_W'($urandom);
        start_pulse();
        do_load(0, 1'b0, -1, stopped);
        finish_load(1'b1, 1'b0, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cbx_ccff_loader.md
Name: cbx_ccff_loader

Overview:
- Sequencer that programs one connection-block configuration chain (ccff_head → mem cells → ccff_tail) from a word-wide stream.
- Serialises host words onto ccff_head and asserts a shift enable for exactly CHAIN_LEN shifts, then signals completion.
- Sits between the tile-level bitstream distributor and the cbx ccff chain. Default CHAIN_LEN covers 16 ipin muxes × 4 SRAM bits.

Parameters:
CHAIN_LEN, 64, number of config flops in the chain; must be a multiple of WORD_W (checked by elaboration assertion)
WORD_W, 8, width of host config words
CNT_W, $clog2(CHAIN_LEN+1), width of the bit counter (derived, do not override)

Ports:
prog_clk  in  1  programming clock, rising edge
prog_reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a load; honoured only in IDLE
abort  in  1  synchronous abort; wins over all other events
s_data  in  WORD_W  config word; MSB is shifted first
s_valid  in  1  s_data valid
s_ready  out  1  loader accepts a word this cycle
ccff_head  out  1  serial bit into the chain
ccff_shift_en  out  1  chain advances on this prog_clk edge (drives clock-gate enable)
ccff_tail  in  1  serial bit from the chain end
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on successful completion
cfg_err  out  1  sticky verify failure (see Optional Feature); cleared by start
bit_cnt  out  CNT_W  bits shifted so far in the current load

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0; shift register and counters 0.
- FSM states: IDLE, LOAD, SHIFT, VERIFY (feature only), DONE.
- IDLE: s_ready=0. start=1 → LOAD; bit_cnt←0; cfg_err←0.
- LOAD: s_ready=1, ccff_shift_en=0. On s_valid&s_ready: capture s_data into shreg, word_bit←0, go to SHIFT. Without s_valid, stay indefinitely.
- SHIFT: s_ready=0; ccff_shift_en=1; ccff_head=shreg[WORD_W-1]. Each cycle shreg shifts left, word_bit++, and bit_cnt++.
  - After WORD_W cycles: if bit_cnt==CHAIN_LEN, go to VERIFY when the feature is enabled, else DONE. Otherwise return to LOAD.
  - There is no word-to-word pipelining; each word costs 1 accept cycle + WORD_W shift cycles.
- Outputs are registered: ccff_head and ccff_shift_en change together, so the chain samples a stable head bit on the edge where shift_en is high.
- The first bit shifted ends up nearest ccff_tail.
- DONE: done=1 for exactly one cycle, ccff_shift_en=0, then IDLE. busy drops in the cycle after done.
- start while busy: ignored, no effect.
- abort=1 in any non-IDLE state: next state IDLE, ccff_shift_en=0, s_ready=0, no done pulse. bit_cnt holds its value for debug; chain contents are undefined.
- abort and start in the same IDLE cycle: abort wins and the FSM stays IDLE.
- Async reset mid-SHIFT: everything returns to reset values immediately.
- bit_cnt never exceeds CHAIN_LEN and never wraps.

Optional Feature:
- Macro CBX_CCFF_VERIFY_EN.
- Enabled:
  - During SHIFT, a CRC-16-CCITT (poly 0x1021, init 0xFFFF) accumulates every ccff_head bit.
  - VERIFY runs CHAIN_LEN cycles with ccff_shift_en=1 and ccff_head=ccff_tail (recirculation, which preserves the configuration), accumulating a second CRC over ccff_tail.
  - At the end, the CRCs are compared; on mismatch cfg_err←1. DONE follows either way.
  - Total load latency = (CHAIN_LEN/WORD_W)·(WORD_W+1) + CHAIN_LEN + 1 cycles from first word acceptance to done.
- Disabled: no VERIFY state, no CRC logic, cfg_err tied 0.

Decomposition:
- Package ccff_pkg: state enum (IDLE, LOAD, SHIFT, VERIFY, DONE), CRC16_POLY=16'h1021, CRC16_INIT=16'hFFFF.
- One sub-module: ccff_crc16 (serial-in CRC, inputs clr/en/bit, output crc[15:0]). Instantiated twice under the macro.

Test Plan:
- Basic load: CHAIN_LEN=64, WORD_W=8, start then 8 words 0x01..0x08 with s_valid held → serial head stream 0x0102…08 MSB-first, 64 shift_en cycles, done pulse 72 cycles after first accept (no verify). Chain model holds the expected 64 bits.
- Backpressure/gaps: s_valid deasserted 5 cycles between every word → s_ready stays high in LOAD, no extra shift_en cycles, bit_cnt=64 at done.
- Abort: assert abort at bit_cnt=20 → next cycle IDLE, shift_en=0, no done, bit_cnt reads 20. A following start restarts with bit_cnt=0.
- Start ignored: pulse start during SHIFT → no state change; total shift_en count still 64.
- Reset mid-operation: drop prog_reset_n at bit_cnt=33 → all outputs 0 asynchronously. After release, IDLE, and a clean load completes.
- Verify (macro on): correct chain model → done with cfg_err=0 after 137 cycles. Fault-injected chain (bit 17 stuck-at-1, loaded value 0) → cfg_err=1 at done, cleared by next start.
